roofline_classifier: RTL and testbench
======================================

# roofline_classifier

Downstream consumer of the arithmetic-intensity estimator's Q16.16 output. It smooths the intensity stream with an exponential moving average and classifies the running workload as memory-bound or compute-bound against a ridge point, using hysteresis and a dwell count. Each classification change is posted as a one-deep valid/ready event to the performance-monitor / scheduler-hint logic.

## Interface
- RIDGE_Q, 32'h000A_0000: roofline ridge point in Q16.16 FLOP/byte (default 10.0).
- HYST_Q, 32'h0001_0000: half-width of the hysteresis band in Q16.16 (default 1.0). Legal only if RIDGE_Q >= HYST_Q and RIDGE_Q+HYST_Q < 2^32.
- ALPHA_SHIFT, 2: EMA weight is 2^-ALPHA_SHIFT; legal range 0..8.
- DWELL, 4: consecutive qualifying samples required to switch state; legal range 1..255.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear of the filter, state and dwell.
- in_valid  in  1  intensity sample valid.
- intensity_q  in  32  Q16.16 intensity. 32'hFFFF_FFFF is the zero-byte saturation code.
- filt_q  out  32  Q16.16 EMA of the accepted samples.
- bound_state  out  2  0 = UNKNOWN, 1 = MEM, 2 = COMPUTE (3 is never driven).
- evt_valid  out  1  classification-change event pending.
- evt_ready  in  1  consumer accepts the event.
- evt_state  out  2  new bound_state carried by the event.
- evt_filt_q  out  32  filt_q value at the transition.
- drop_cnt  out  16  saturating count of events overwritten before acceptance.

## Operation
- Reset: every output is 0. This includes filt_q, bound_state = UNKNOWN, evt_valid, evt_state, evt_filt_q and drop_cnt. The seeded flag and the dwell counter also clear.
- Accepted sample: in_valid=1, intensity_q != 32'hFFFF_FFFF, and clear=0.
- A saturated sample (32'hFFFF_FFFF) is ignored entirely: no change to the filter, dwell, or state.
- Filter, first accepted sample after reset/clear: filt_next = intensity_q, and the seeded flag is set.
- Filter, later samples: d = {1'b0,x} - {1'b0,filt} as 33-bit signed; filt_next = filt + (d >>> ALPHA_SHIFT), truncated to 32 bits.
  - The result always lies between filt and x, so it never overflows.
- Thresholds are constants computed at elaboration: HI = RIDGE_Q+HYST_Q, LO = RIDGE_Q-HYST_Q.
- Candidate state is derived from filt_next:
  - State UNKNOWN: COMPUTE if filt_next >= RIDGE_Q, else MEM.
  - State MEM or COMPUTE: COMPUTE if filt_next >= HI; MEM if filt_next < LO; otherwise no candidate (hysteresis band).
- Dwell counter (8-bit):
  - Candidate == state, or no candidate: counter is set to 0.
  - Candidate differs from the previous sample's candidate: counter is set to 1.
  - Otherwise: counter increments.
  - When the count reaches DWELL: bound_state <= candidate, counter <= 0, and an event is posted.
- Event register:
  - On a transition: evt_valid <= 1, evt_state <= new state, evt_filt_q <= filt_next.
  - If evt_valid=1 and evt_ready=0 in the transition cycle, the payload is overwritten and drop_cnt increments (saturating at 16'hFFFF).
  - If evt_ready=1 in the transition cycle, the old event counts as accepted and the new one loads; no drop.
  - evt_valid falls on an evt_valid & evt_ready edge when no new transition occurs in that cycle.
- clear:
  - Resets filt_q to 0, the seeded flag, the dwell counter, and bound_state to UNKNOWN.
  - Has priority over in_valid in the same cycle.
  - Posts no event. The event register and drop_cnt are untouched.
- Precedence: rst > clear > sample processing.

## Timing
- The sample is registered at edge N. filt_q, bound_state and the event outputs reflect it after edge N (1-cycle latency).
- There is no combinational path from the input ports to any output.
- Back-to-back samples are accepted every cycle; there is no input backpressure.
- evt_valid, evt_state and evt_filt_q are stable while evt_valid=1 && evt_ready=0, unless overwritten by a later transition (counted in drop_cnt).
- rst asserted mid-dwell or with an event pending discards everything. The first cycle after deassertion behaves as post-reset.

## Test plan
- Seeding and first class: after rst, 4 samples of 0x0014_0000 with evt_ready=1.
  - Required: filt_q = 0x0014_0000 after sample 1.
  - Required: bound_state goes 0 -> 2 after sample 4, with a 1-cycle evt_valid pulse, evt_state=2, evt_filt_q=0x0014_0000.
- Hysteresis hold: from COMPUTE with filt 20.0, 40 samples of 0x0009_8000 (9.5).
  - Required: filt_q converges toward 9.5 and never drops below LO=9.0; bound_state stays 2 with no event.
- Down-transition: from COMPUTE with filt 20.0, continuous samples of 0x0002_0000.
  - Required: filt_q = 15.5, 12.125, 9.594, 7.695 (<LO, dwell=1), ...
  - Required: bound_state goes to 1 exactly after the 7th sample; evt_state=1.
- Saturation code: 0xFFFF_FFFF interleaved with 0x0014_0000.
  - Required: filt_q and dwell progress are identical to the run without the saturated samples.
- Backpressure: evt_ready=0, force COMPUTE then MEM transitions.
  - Required: evt_state=1, drop_cnt=1, and evt_valid stays high.
  - Then evt_ready=1 for one cycle: evt_valid=0 next cycle.
- Clear and reset mid-dwell: clear after 3 of 4 qualifying samples, in the same cycle as in_valid.
  - Required: sample ignored, bound_state=0, next sample reseeds filt_q, 4 more samples needed.
  - Repeat with rst: all outputs 0.

Source files
------------

// File: rtl/roofline_classifier_if.sv
// Sample input stream and classification-change event channel of roofline_classifier.
interface roofline_classifier_if;
    logic        in_valid;
    logic [31:0] intensity_q;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_state;
    logic [31:0] evt_filt_q;

    modport master (
        output in_valid, intensity_q, evt_ready,
        input  evt_valid, evt_state, evt_filt_q
    );

    modport slave (
        input  in_valid, intensity_q, evt_ready,
        output evt_valid, evt_state, evt_filt_q
    );
endinterface

// File: rtl/roofline_classifier.sv
// EMA-smoothed arithmetic intensity classified as memory- or compute-bound with
// hysteresis and dwell; each classification change is posted as a one-deep event.
module roofline_classifier #(
    parameter logic [31:0] RIDGE_Q     = 32'h000A_0000,
    parameter logic [31:0] HYST_Q      = 32'h0001_0000,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned DWELL       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    roofline_classifier_if.slave        bus,
    output logic [31:0]                 filt_q,
    output logic [1:0]                  bound_state,
    output logic [15:0]                 drop_cnt
);

    localparam logic [31:0] HI_Q    = RIDGE_Q + HYST_Q;
    localparam logic [31:0] LO_Q    = RIDGE_Q - HYST_Q;
    localparam logic [7:0]  DWELL_W = 8'(DWELL);
    localparam logic [31:0] SAT_CODE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_MEM     = 2'd1,
        ST_COMPUTE = 2'd2
    } bound_e;

    bound_e      state_q, state_d;
    bound_e      prev_cand_q, prev_cand_d;
    bound_e      cand_c;
    logic [31:0] filt_r, filt_d;
    logic        seeded_q, seeded_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        evt_valid_q, evt_valid_d;
    logic [1:0]  evt_state_q, evt_state_d;
    logic [31:0] evt_filt_q, evt_filt_d;
    logic [15:0] drop_q, drop_d;

    logic               accept_c;
    logic signed [32:0] diff_c;
    logic signed [32:0] step_c;
    logic [31:0]        filt_calc_c;

    // Filter update: the shifted difference keeps the result between filt and x.
    assign accept_c    = bus.in_valid && (bus.intensity_q != SAT_CODE) && !clear;
    assign diff_c      = $signed({1'b0, bus.intensity_q}) - $signed({1'b0, filt_r});
    assign step_c      = diff_c >>> ALPHA_SHIFT;
    assign filt_calc_c = seeded_q ? 32'($unsigned(step_c) + {1'b0, filt_r})
                                  : bus.intensity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNKNOWN;
            prev_cand_q <= ST_UNKNOWN;
            filt_r      <= '0;
            seeded_q    <= 1'b0;
            dwell_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_state_q <= '0;
            evt_filt_q  <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            prev_cand_q <= prev_cand_d;
            filt_r      <= filt_d;
            seeded_q    <= seeded_d;
            dwell_q     <= dwell_d;
            evt_valid_q <= evt_valid_d;
            evt_state_q <= evt_state_d;
            evt_filt_q  <= evt_filt_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_cand_d = prev_cand_q;
        filt_d      = filt_r;
        seeded_d    = seeded_q;
        dwell_d     = dwell_q;
        evt_valid_d = evt_valid_q;
        evt_state_d = evt_state_q;
        evt_filt_d  = evt_filt_q;
        drop_d      = drop_q;
        cand_c      = ST_UNKNOWN;

        if (evt_valid_q && bus.evt_ready) begin
            evt_valid_d = 1'b0;
        end

        if (clear) begin
            state_d     = ST_UNKNOWN;
            prev_cand_d = ST_UNKNOWN;
            filt_d      = '0;
            seeded_d    = 1'b0;
            dwell_d     = '0;
        end else if (accept_c) begin
            filt_d   = filt_calc_c;
            seeded_d = 1'b1;

            // ST_UNKNOWN doubles as "no candidate" inside the hysteresis band.
            if (state_q == ST_UNKNOWN) begin
                cand_c = (filt_calc_c >= RIDGE_Q) ? ST_COMPUTE : ST_MEM;
            end else if (filt_calc_c >= HI_Q) begin
                cand_c = ST_COMPUTE;
            end else if (filt_calc_c < LO_Q) begin
                cand_c = ST_MEM;
            end
            prev_cand_d = cand_c;

            if (cand_c == ST_UNKNOWN || cand_c == state_q) begin
                dwell_d = '0;
            end else if (cand_c != prev_cand_q) begin
                dwell_d = 8'd1;
            end else begin
                dwell_d = dwell_q + 8'd1;
            end

            if (dwell_d == DWELL_W) begin
                state_d     = cand_c;
                dwell_d     = '0;
                evt_valid_d = 1'b1;
                evt_state_d = cand_c;
                evt_filt_d  = filt_calc_c;
                if (evt_valid_q && !bus.evt_ready && drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end
    end

    assign filt_q        = filt_r;
    assign bound_state   = state_q;
    assign drop_cnt      = drop_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_state = evt_state_q;
    assign bus.evt_filt_q = evt_filt_q;

endmodule

// File: tb/tb_roofline_classifier.sv
// Directed bench for roofline_classifier: reference model feeds a scoreboard queue,
// plus fixed expected values for the seeding, down-transition and backpressure cases.
module tb_roofline_classifier;

    localparam logic [31:0] RIDGE = 32'h000A_0000;
    localparam logic [31:0] HI    = 32'h000B_0000;
    localparam logic [31:0] LO    = 32'h0009_0000;
    localparam logic [31:0] V20   = 32'h0014_0000;
    localparam logic [31:0] V2    = 32'h0002_0000;
    localparam logic [31:0] V5    = 32'h0005_0000;
    localparam logic [31:0] SAT   = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] filt;
        logic [1:0]  st;
        logic        ev;
        logic [1:0]  es;
        logic [31:0] ef;
        logic [15:0] drop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [31:0] filt_q;
    logic [1:0]  bound_state;
    logic [15:0] drop_cnt;

    roofline_classifier_if bus();

    roofline_classifier dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .bus         (bus),
        .filt_q      (filt_q),
        .bound_state (bound_state),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // Reference model state
    longint      m_filt   = 0;
    logic        m_seeded = 1'b0;
    logic [1:0]  m_state  = 2'd0;
    int          m_dwell  = 0;
    logic [1:0]  m_prev   = 2'd0;
    logic        m_ev     = 1'b0;
    logic [1:0]  m_es     = 2'd0;
    logic [31:0] m_ef     = '0;
    logic [15:0] m_drop   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic [31:0] x, input logic rdy,
                         input logic clr, input logic rs);
        longint     xl;
        longint     fn;
        logic [1:0] cand;
        logic       ev_old;
        if (rs) begin
            m_filt = 0; m_seeded = 0; m_state = 0; m_dwell = 0; m_prev = 0;
            m_ev = 0; m_es = 0; m_ef = '0; m_drop = '0;
            return;
        end
        ev_old = m_ev;
        if (m_ev && rdy) m_ev = 1'b0;
        if (clr) begin
            m_filt = 0; m_seeded = 0; m_state = 0; m_dwell = 0; m_prev = 0;
        end else if (v && x != SAT) begin
            xl = longint'({32'd0, x});
            fn = m_seeded ? m_filt + ((xl - m_filt) >>> 2) : xl;
            if (m_state == 2'd0)        cand = (fn >= longint'({32'd0, RIDGE})) ? 2'd2 : 2'd1;
            else if (fn >= longint'({32'd0, HI})) cand = 2'd2;
            else if (fn < longint'({32'd0, LO}))  cand = 2'd1;
            else                        cand = 2'd0;
            if (cand == 2'd0 || cand == m_state) m_dwell = 0;
            else if (cand != m_prev)             m_dwell = 1;
            else                                 m_dwell = m_dwell + 1;
            m_prev = cand;
            if (m_dwell == 4) begin
                m_state = cand;
                m_dwell = 0;
                if (ev_old && !rdy && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                m_ev = 1'b1;
                m_es = cand;
                m_ef = 32'(fn);
            end
            m_filt = fn;
            m_seeded = 1'b1;
        end
    endtask

    // One clock of stimulus; expected outputs queued at drive time, checked after the edge.
    task automatic step(input logic v, input logic [31:0] x, input logic rdy,
                        input logic clr, input logic rs);
        exp_t e;
        model(v, x, rdy, clr, rs);
        e = '{filt: 32'(m_filt), st: m_state, ev: m_ev, es: m_es, ef: m_ef, drop: m_drop};
        sb.push_back(e);
        bus.in_valid    = v;
        bus.intensity_q = x;
        bus.evt_ready   = rdy;
        clear           = clr;
        rst             = rs;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("filt_q",      filt_q,        e.filt);
        chk("bound_state", 32'(bound_state), 32'(e.st));
        chk("evt_valid",   32'(bus.evt_valid), 32'(e.ev));
        chk("evt_state",   32'(bus.evt_state), 32'(e.es));
        chk("evt_filt_q",  bus.evt_filt_q, e.ef);
        chk("drop_cnt",    32'(drop_cnt), 32'(e.drop));
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, rdy, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_filt"},  filt_q, 32'd0);
        chk({tag, "_state"}, 32'(bound_state), 32'd0);
        chk({tag, "_ev"},    32'(bus.evt_valid), 32'd0);
        chk({tag, "_es"},    32'(bus.evt_state), 32'd0);
        chk({tag, "_ef"},    bus.evt_filt_q, 32'd0);
        chk({tag, "_drop"},  32'(drop_cnt), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.intensity_q = '0; bus.evt_ready = 1'b1;
        clear = 1'b0; rst = 1'b1;

        // Reset
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_all_zero("reset");

        // Seeding and first classification
        for (int i = 0; i < 4; i++) begin
            step(1'b1, V20, 1'b1, 1'b0, 1'b0);
            if (i == 0) chk("seed_filt", filt_q, V20);
            if (i < 3)  chk("seed_state_unknown", 32'(bound_state), 32'd0);
        end
        chk("seed_state", 32'(bound_state), 32'd2);
        chk("seed_ev", 32'(bus.evt_valid), 32'd1);
        chk("seed_es", 32'(bus.evt_state), 32'd2);
        chk("seed_ef", bus.evt_filt_q, V20);
        idle(1'b1);
        chk("seed_ev_pulse", 32'(bus.evt_valid), 32'd0);

        // Hysteresis hold at 9.5
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'h0009_8000, 1'b1, 1'b0, 1'b0);
            chk("hyst_floor", 32'(filt_q >= LO), 32'd1);
            chk("hyst_state", 32'(bound_state), 32'd2);
            chk("hyst_noevt", 32'(bus.evt_valid), 32'd0);
        end

        // Down-transition from COMPUTE at 20.0
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, V20, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, V2, 1'b1, 1'b0, 1'b0);
            case (i)
                0: chk("down_f1", filt_q, 32'h000F_8000);
                1: chk("down_f2", filt_q, 32'h000C_2000);
                2: chk("down_f3", filt_q, 32'h0009_9800);
                3: chk("down_f4", filt_q, 32'h0007_B200);
                default: ;
            endcase
            chk("down_state", 32'(bound_state), (i == 6) ? 32'd1 : 32'd2);
        end
        chk("down_es", 32'(bus.evt_state), 32'd1);
        chk("down_ev", 32'(bus.evt_valid), 32'd1);
        idle(1'b1);

        // Saturation code interleaved
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, V20, 1'b1, 1'b0, 1'b0);
        step(1'b1, SAT, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0010_0000, 1'b1, 1'b0, 1'b0);
        chk("sat_filt2", filt_q, 32'h0013_0000);
        step(1'b1, SAT, 1'b1, 1'b0, 1'b0);
        step(1'b1, SAT, 1'b1, 1'b0, 1'b0);
        chk("sat_filt_hold", filt_q, 32'h0013_0000);
        step(1'b1, V20, 1'b1, 1'b0, 1'b0);
        chk("sat_state3", 32'(bound_state), 32'd0);
        step(1'b1, SAT, 1'b1, 1'b0, 1'b0);
        step(1'b1, V20, 1'b1, 1'b0, 1'b0);
        chk("sat_state4", 32'(bound_state), 32'd2);
        idle(1'b1);

        // Backpressure: COMPUTE then MEM with no acceptance
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, V20, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, V2, 1'b0, 1'b0, 1'b0);
        chk("bp_es", 32'(bus.evt_state), 32'd1);
        chk("bp_drop", 32'(drop_cnt), 32'd1);
        chk("bp_ev", 32'(bus.evt_valid), 32'd1);
        idle(1'b1);
        chk("bp_ev_drop", 32'(bus.evt_valid), 32'd0);

        // Clear mid-dwell, same cycle as a sample
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, V20, 1'b0, 1'b0, 1'b0);
        step(1'b1, V20, 1'b0, 1'b1, 1'b0);
        chk("clr_state", 32'(bound_state), 32'd0);
        chk("clr_filt", filt_q, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, V5, 1'b0, 1'b0, 1'b0);
            if (i == 0) chk("clr_reseed", filt_q, V5);
            chk("clr_state_dwell", 32'(bound_state), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("clr_drop_kept", 32'(drop_cnt), 32'd1);

        // Reset mid-dwell with an event pending
        for (int i = 0; i < 3; i++) step(1'b1, V20, 1'b0, 1'b0, 1'b0);
        step(1'b1, V20, 1'b0, 1'b0, 1'b1);
        check_all_zero("rst_mid");
        step(1'b1, V20, 1'b1, 1'b0, 1'b0);
        chk("rst_reseed", filt_q, V20);
        chk("rst_reseed_state", 32'(bound_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
